// File: rtl/fetch_cycle_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
`timescale 1ns/1ps
interface fetch_cycle_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_cycle.sv
// Fetch stage with IF/ID register, hold buffer for stalled returns and discard of stale requests.
// Optional macro FETCH_MISALIGN_TRAP_EN: flag misaligned redirect targets on misalignF.
`timescale 1ns/1ps
module fetch_cycle #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               StallF,
  input  logic               FlushD,
  input  logic               PCSrcE,
  input  logic [31:0]        PCTargetE,
  fetch_cycle_if.master      imem,
  output logic [31:0]        instructionF,
  output logic [31:0]        PCF,
  output logic [31:0]        PCPlus4F,
  output logic               validF,
  output logic               misalignF
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} fetchState_t;

  fetchState_t stateQ, stateD;
  logic [31:0] pc_q;
  logic [31:0] disc_addr_q;
  logic [31:0] holdWordQ;

  logic        wordAvail;
  logic [31:0] availWord;
  logic        wordConsumed;
  logic        captureDisc;
  logic        captureHold;
  logic [31:0] targetAligned;

  function automatic logic [31:0] alignPc(input logic [31:0] target);
    return {target[31:2], 2'b00};
  endfunction

  function automatic logic isMisaligned(input logic [31:0] target);
    return target[1:0] != 2'b00;
  endfunction

  assign targetAligned = alignPc(PCTargetE);

  always_comb begin
    imem.imem_req  = (stateQ == FETCH) || (stateQ == DISCARD);
    imem.imem_addr = (stateQ == DISCARD) ? disc_addr_q : pc_q;
  end

  // A word offered to IF/ID comes either live from memory or from the hold buffer
  always_comb begin
    wordAvail    = ((stateQ == FETCH) && imem.imem_ready) || (stateQ == HOLD);
    availWord    = (stateQ == HOLD) ? holdWordQ : imem.imem_rdata;
    wordConsumed = wordAvail && !StallF && !FlushD && !PCSrcE;
  end

  always_comb begin
    stateD      = stateQ;
    captureDisc = 1'b0;
    captureHold = 1'b0;
    unique case (stateQ)
      IDLE: stateD = FETCH;
      FETCH: begin
        if (PCSrcE) begin
          if (!imem.imem_ready) begin
            stateD      = DISCARD;
            captureDisc = 1'b1;
          end
        end else if (imem.imem_ready && !wordConsumed) begin
          stateD      = HOLD;
          captureHold = 1'b1;
        end
      end
      HOLD: begin
        if (PCSrcE || wordConsumed) stateD = FETCH;
      end
      DISCARD: begin
        if (imem.imem_ready) stateD = FETCH;
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ      <= IDLE;
      pc_q        <= RESET_PC;
      disc_addr_q <= 32'h0;
      holdWordQ   <= 32'h0;
    end else begin
      stateQ <= stateD;
      if (PCSrcE)            pc_q <= targetAligned;
      else if (wordConsumed) pc_q <= pc_q + 32'd4;
      if (captureDisc) disc_addr_q <= pc_q;
      if (captureHold) holdWordQ   <= imem.imem_rdata;
    end
  end

  // IF/ID boundary: bubble on redirect/flush beats stall, stall beats load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instructionF <= NOP_INSTR;
      PCF          <= 32'h0;
      validF       <= 1'b0;
    end else if (PCSrcE || FlushD) begin
      instructionF <= NOP_INSTR;
      validF       <= 1'b0;
    end else if (!StallF) begin
      if (wordAvail) begin
        instructionF <= availWord;
        PCF          <= pc_q;
        validF       <= 1'b1;
      end else begin
        instructionF <= NOP_INSTR;
        validF       <= 1'b0;
      end
    end
  end

  assign PCPlus4F = PCF + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalignQ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) misalignQ <= 1'b0;
    else        misalignQ <= PCSrcE && isMisaligned(PCTargetE);
  end

  assign misalignF = misalignQ;
`else
  assign misalignF = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_cycle.sv
// Self-checking bench for fetch_cycle: directed scenarios plus randomized hazards
// against a transaction-level reference model of the fetch stage.
`timescale 1ns/1ps
module tb_fetch_cycle;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        StallF = 1'b0;
  logic        FlushD = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'h0;
  logic        rdy = 1'b0;
  logic [31:0] instructionF, PCF, PCPlus4F;
  logic        validF, misalignF;

  int checks = 0;
  int errors = 0;

  fetch_cycle_if bus ();

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F96;
  endfunction

  assign bus.imem_ready = rdy;
  assign bus.imem_rdata = memWord(bus.imem_addr);

  fetch_cycle dut (
    .clk          (clk),
    .reset        (reset),
    .StallF       (StallF),
    .FlushD       (FlushD),
    .PCSrcE       (PCSrcE),
    .PCTargetE    (PCTargetE),
    .imem         (bus),
    .instructionF (instructionF),
    .PCF          (PCF),
    .PCPlus4F     (PCPlus4F),
    .validF       (validF),
    .misalignF    (misalignF)
  );

  always #5 clk = ~clk;

  // Reference model: fetch PC, an optional parked word, an optional stale request
  logic        mStarted, mHeld, mDisc, mValid, mMis;
  logic [31:0] mPc, mHeldWord, mDiscAddr, mInstr, mPcF;

  task automatic model_reset();
    mStarted = 0; mHeld = 0; mDisc = 0; mValid = 0; mMis = 0;
    mPc = 32'h0; mHeldWord = 32'h0; mDiscAddr = 32'h0; mInstr = NOP; mPcF = 32'h0;
  endtask

  function automatic logic expReq();
    return mStarted && !mHeld;
  endfunction

  function automatic logic [31:0] expAddr();
    return mDisc ? mDiscAddr : mPc;
  endfunction

  task automatic model_step(input logic s, input logic f, input logic b,
                            input logic [31:0] t, input logic r);
    logic        live, avail, take;
    logic [31:0] word;
    live  = mStarted && !mHeld && !mDisc;
    avail = mHeld || (live && r);
    word  = mHeld ? mHeldWord : memWord(mPc);
    take  = avail && !s && !f && !b;
    if (b || f) begin
      mInstr = NOP; mValid = 0;
    end else if (!s) begin
      if (avail) begin mInstr = word; mPcF = mPc; mValid = 1; end
      else begin mInstr = NOP; mValid = 0; end
    end
    if (!mStarted) mStarted = 1;
    else if (mDisc) begin
      if (r) mDisc = 0;
    end else if (mHeld) begin
      if (b || take) mHeld = 0;
    end else if (b && !r) begin
      mDisc = 1; mDiscAddr = mPc;
    end else if (r && !b && !take) begin
      mHeld = 1; mHeldWord = word;
    end
    if (b) mPc = t & 32'hFFFF_FFFC;
    else if (take) mPc = mPc + 32'd4;
`ifdef FETCH_MISALIGN_TRAP_EN
    mMis = b && (t[1:0] != 2'b00);
`else
    mMis = 0;
`endif
  endtask

  task automatic drive_cycle(input logic s, input logic f, input logic b,
                             input logic [31:0] t, input logic r);
    StallF = s; FlushD = f; PCSrcE = b; PCTargetE = t; rdy = r;
    model_step(s, f, b, t, r);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 0; StallF = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0; rdy = 1;
    model_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", bus.imem_req); end
    checks++; if (instructionF !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", instructionF, NOP); end
    checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL reset_pcf got %h exp 0", PCF); end
    checks++; if (PCPlus4F !== 32'h4) begin errors++; $display("FAIL reset_pcplus4 got %h exp 4", PCPlus4F); end
    checks++; if (validF !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", validF); end
    checks++; if (misalignF !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", misalignF); end
    rdy = 0;
    reset = 1;
  endtask

  task automatic test_sequential();
    drive_cycle(0, 0, 0, 0, 1);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++; $display("FAIL seq_first_req got %b/%h exp 1/00000000", bus.imem_req, bus.imem_addr); end
    checks++; if (validF !== 1'b0) begin errors++; $display("FAIL seq_idle_valid got %b exp 0", validF); end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 0, 0, 0, 1);
      checks++; if (validF !== 1'b1 || PCF !== 32'(4 * i) || instructionF !== memWord(32'(4 * i))) begin
        errors++; $display("FAIL seq_ifid[%0d] got %b/%h/%h exp 1/%h/%h", i, validF, PCF, instructionF,
                           32'(4 * i), memWord(32'(4 * i))); end
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * i + 4)) begin
        errors++; $display("FAIL seq_addr[%0d] got %b/%h exp 1/%h", i, bus.imem_req, bus.imem_addr, 32'(4 * i + 4)); end
    end
  endtask

  task automatic test_wait_states();
    drive_cycle(0, 0, 1, 32'h10, 1);
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10 || validF !== 1'b0) begin
        errors++; $display("FAIL wait_hold[%0d] got %b/%h/v%b exp 1/00000010/v0", i, bus.imem_req, bus.imem_addr, validF); end
      drive_cycle(0, 0, 0, 0, 0);
    end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10 || validF !== 1'b0) begin
      errors++; $display("FAIL wait_last got %b/%h/v%b exp 1/00000010/v0", bus.imem_req, bus.imem_addr, validF); end
    drive_cycle(0, 0, 0, 0, 1);
    checks++; if (validF !== 1'b1 || PCF !== 32'h10 || instructionF !== memWord(32'h10)) begin
      errors++; $display("FAIL wait_load got %b/%h/%h exp 1/00000010/%h", validF, PCF, instructionF, memWord(32'h10)); end
  endtask

  task automatic test_stall_hold();
    drive_cycle(0, 0, 1, 32'h1C, 1);
    drive_cycle(0, 0, 0, 0, 1);
    drive_cycle(1, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d] got %b exp 0", i, bus.imem_req); end
      checks++; if (validF !== 1'b1 || PCF !== 32'h1C || instructionF !== memWord(32'h1C)) begin
        errors++; $display("FAIL stall_ifid[%0d] got %b/%h/%h exp 1/0000001c/%h", i, validF, PCF, instructionF, memWord(32'h1C)); end
      if (i == 0) drive_cycle(1, 0, 0, 0, 0);
    end
    drive_cycle(0, 0, 0, 0, 0);
    checks++; if (validF !== 1'b1 || PCF !== 32'h20 || instructionF !== memWord(32'h20)) begin
      errors++; $display("FAIL stall_release got %b/%h/%h exp 1/00000020/%h", validF, PCF, instructionF, memWord(32'h20)); end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h24) begin
      errors++; $display("FAIL stall_next got %b/%h exp 1/00000024", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_redirect_discard();
    drive_cycle(0, 0, 1, 32'h40, 1);
    drive_cycle(0, 0, 1, 32'h100, 0);
    for (int i = 0; i < 2; i++) begin
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40 || validF !== 1'b0) begin
        errors++; $display("FAIL disc_stale[%0d] got %b/%h/v%b exp 1/00000040/v0", i, bus.imem_req, bus.imem_addr, validF); end
      drive_cycle(0, 0, 0, 0, i == 1);
    end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100 || validF !== 1'b0) begin
      errors++; $display("FAIL disc_after got %b/%h/v%b exp 1/00000100/v0", bus.imem_req, bus.imem_addr, validF); end
    drive_cycle(0, 0, 0, 0, 1);
    checks++; if (validF !== 1'b1 || PCF !== 32'h100 || instructionF !== memWord(32'h100)) begin
      errors++; $display("FAIL disc_target got %b/%h/%h exp 1/00000100/%h", validF, PCF, instructionF, memWord(32'h100)); end
  endtask

  task automatic test_misalign();
    logic expMis;
`ifdef FETCH_MISALIGN_TRAP_EN
    expMis = 1'b1;
`else
    expMis = 1'b0;
`endif
    drive_cycle(0, 0, 1, 32'h102, 1);
    checks++; if (misalignF !== expMis) begin errors++; $display("FAIL mis_pulse got %b exp %b", misalignF, expMis); end
    checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL mis_addr got %h exp 00000100", bus.imem_addr); end
    drive_cycle(0, 0, 0, 0, 0);
    checks++; if (misalignF !== 1'b0) begin errors++; $display("FAIL mis_clear got %b exp 0", misalignF); end
  endtask

  task automatic test_wrap();
    drive_cycle(0, 0, 1, 32'hFFFF_FFFC, 1);
    drive_cycle(0, 0, 0, 0, 1);
    checks++; if (validF !== 1'b1 || PCF !== 32'hFFFF_FFFC || PCPlus4F !== 32'h0) begin
      errors++; $display("FAIL wrap_ifid got %b/%h/%h exp 1/fffffffc/00000000", validF, PCF, PCPlus4F); end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_addr got %b/%h exp 1/00000000", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_reset_midrequest();
    drive_cycle(0, 0, 1, 32'h80, 0);
    drive_cycle(0, 0, 0, 0, 0);
    #2 reset = 0;
    #1;
    checks++; if (bus.imem_req !== 1'b0 || validF !== 1'b0) begin
      errors++; $display("FAIL midreset_abandon got %b/v%b exp 0/v0", bus.imem_req, validF); end
    model_reset();
    rdy = 1;
    @(negedge clk);
    reset = 1;
    drive_cycle(0, 0, 0, 0, 1);
    checks++; if (validF !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++; $display("FAIL midreset_first got v%b/%b/%h exp v0/1/00000000", validF, bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_random();
    logic s, f, b, r;
    logic [31:0] t;
    for (int i = 0; i < 600; i++) begin
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 9) == 0);
      b = ($urandom_range(0, 11) == 0);
      r = ($urandom_range(0, 9) < 6);
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                      : ($urandom & 32'h0000_0FFF);
      drive_cycle(s, f, b, t, r);
      checks++; if (bus.imem_req !== expReq()) begin
        errors++; $display("FAIL rand_req[%0d] got %b exp %b", i, bus.imem_req, expReq()); end
      if (expReq()) begin
        checks++; if (bus.imem_addr !== expAddr()) begin
          errors++; $display("FAIL rand_addr[%0d] got %h exp %h", i, bus.imem_addr, expAddr()); end
      end
      checks++; if (validF !== mValid || instructionF !== mInstr) begin
        errors++; $display("FAIL rand_ifid[%0d] got %b/%h exp %b/%h", i, validF, instructionF, mValid, mInstr); end
      if (mValid) begin
        checks++; if (PCF !== mPcF || PCPlus4F !== mPcF + 32'd4) begin
          errors++; $display("FAIL rand_pc[%0d] got %h/%h exp %h/%h", i, PCF, PCPlus4F, mPcF, mPcF + 32'd4); end
      end
      checks++; if (misalignF !== mMis) begin
        errors++; $display("FAIL rand_mis[%0d] got %b exp %b", i, misalignF, mMis); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_states();
    test_stall_hold();
    test_redirect_discard();
    test_misalign();
    test_wrap();
    test_reset_midrequest();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
